// File: rtl/mux_scan_ctrl_if.sv
// Scan-controller handshake bundle: scan control, the mux select/return pair
// and the captured result. master = controller side, slave = environment side.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] sample;
  logic       valid;
  logic       busy;

  modport master (
    input  start, cont, y_in,
    output sel, sample, valid, busy
  );

  modport slave (
    output start, cont, y_in,
    input  sel, sample, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 channel mux: steps sel 0..3, holds each channel for DWELL
// cycles, captures y_in at the end of each window and emits a 4-bit word with a valid pulse.
// Optional feature macro: MUX_SCAN_SETTLE_EN (one blanking cycle after every sel change).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sel parked at 0, busy low
// SCAN  | stepping channels, counting dwell, capturing y_in per channel
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.master bus
);

`ifdef MUX_SCAN_SETTLE_EN
  localparam logic SETTLE = 1'b1;
`else
  localparam logic SETTLE = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             blank_q, blank_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    blank_d  = blank_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          sel_d   = 2'd0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          blank_d = SETTLE;
        end
      end

      SCAN: begin
        // blank_q is only ever set in the settle build; it skips one count
        if (blank_q) begin
          blank_d = 1'b0;
        end else if (cnt_q == DWELL_M1) begin
          cnt_d            = '0;
          shadow_d[sel_q]  = bus.y_in;
          blank_d          = SETTLE;
          if (sel_q != 2'd3) begin
            sel_d = sel_q + 2'd1;
          end else begin
            // channel 3 goes straight into the result, bypassing the shadow
            sample_d = {bus.y_in, shadow_q[2:0]};
            valid_d  = 1'b1;
            sel_d    = 2'd0;
            if (!bus.cont) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              blank_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        blank_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      shadow_q <= 4'd0;
      sample_q <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      blank_q  <= blank_d;
    end
  end

  assign bus.sel    = sel_q;
  assign bus.sample = sample_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one DWELL=4 instance for single-shot/reset cases,
// one DWELL=2 instance for continuous mode. Honors MUX_SCAN_SETTLE_EN window length.
module tb_mux_scan_ctrl;

  localparam int DA = 4;
  localparam int DB = 2;
`ifdef MUX_SCAN_SETTLE_EN
  localparam int WA = DA + 1;
  localparam int WB = DB + 1;
`else
  localparam int WA = DA;
  localparam int WB = DB;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [3:0] ch_a;
  logic [3:0] ch_b;

  always #5 clk = ~clk;

  mux_scan_ctrl_if bus_a();
  mux_scan_ctrl_if bus_b();

  // behavioural 4:1 mux feeding each controller
  assign bus_a.y_in = ch_a[bus_a.sel];
  assign bus_b.y_in = ch_b[bus_b.sel];

  mux_scan_ctrl #(.DWELL(DA), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  mux_scan_ctrl #(.DWELL(DB), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge with dut_a idle. p1/p2 = edge offsets from E0 where a
  // stray start is presented (0 = none).
  task automatic scan_a(input int p1, input int p2, input logic [3:0] exp_sample);
    bus_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = (p1 == 1) || (p2 == 1);
    check("a_sel_e0", 32'(bus_a.sel), 32'd0);
    check("a_busy_e0", 32'(bus_a.busy), 32'd1);
    for (int t = 1; t <= 4*WA + 1; t++) begin
      @(posedge clk);
      @(negedge clk);
      bus_a.start = ((t + 1) == p1) || ((t + 1) == p2);
      check("a_sel", 32'(bus_a.sel), (t < 4*WA) ? 32'(t / WA) : 32'd0);
      check("a_valid", 32'(bus_a.valid), 32'(t == 4*WA));
      check("a_busy", 32'(bus_a.busy), 32'(t < 4*WA));
      if (t == 4*WA) check("a_sample", 32'(bus_a.sample), 32'(exp_sample));
    end
    bus_a.start = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("a_no_rescan", 32'(bus_a.busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_a.cont  = 1'b0;
    bus_b.start = 1'b0;
    bus_b.cont  = 1'b0;
    ch_a = 4'd0;
    ch_b = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_sel", 32'(bus_a.sel), 32'd0);
    check("rst_sample", 32'(bus_a.sample), 32'd0);
    check("rst_valid", 32'(bus_a.valid), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_busy_b", 32'(bus_b.busy), 32'd0);

    // single scan, a=1 b=0 c=1 d=1
    ch_a = 4'b1101;
    scan_a(0, 0, 4'b1101);

    // same scan with start pulses at E0+3 and E0+10 that must be ignored
    scan_a(3, 10, 4'b1101);

    // reset while sel=2, held two cycles
    bus_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (2*WA) @(negedge clk);
    check("mid_sel2", 32'(bus_a.sel), 32'd2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mrst_sel", 32'(bus_a.sel), 32'd0);
    check("mrst_sample", 32'(bus_a.sample), 32'd0);
    check("mrst_valid", 32'(bus_a.valid), 32'd0);
    check("mrst_busy", 32'(bus_a.busy), 32'd0);
    for (int t = 0; t < 4*WA + 2; t++) begin
      @(negedge clk);
      check("mrst_no_valid", 32'(bus_a.valid), 32'd0);
      check("mrst_idle", 32'(bus_a.busy), 32'd0);
    end

    // fresh start after reset, different pattern
    ch_a = 4'b1010;
    scan_a(0, 0, 4'b1010);

    // continuous mode on dut_b; inputs change between scans, cont dropped mid second scan
    ch_b = 4'b1101;
    bus_b.cont  = 1'b1;
    bus_b.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0;
    check("b_sel_e0", 32'(bus_b.sel), 32'd0);
    for (int t = 1; t <= 8*WB + 2; t++) begin
      @(posedge clk);
      @(negedge clk);
      check("b_sel", 32'(bus_b.sel), (t < 8*WB) ? 32'((t % (4*WB)) / WB) : 32'd0);
      check("b_valid", 32'(bus_b.valid), 32'((t == 4*WB) || (t == 8*WB)));
      check("b_busy", 32'(bus_b.busy), 32'(t < 8*WB));
      if (t == 4*WB) begin
        check("b_sample1", 32'(bus_b.sample), 32'h0000000d);
        ch_b = 4'b0110;
      end
      if (t == 8*WB) check("b_sample2", 32'(bus_b.sample), 32'h00000006);
      if (t == 5*WB) bus_b.cont = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
